// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode constants, default widths,
// response-slot state type and the response tag width helper.
package alu_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CODE_W_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BLT = 4'b1101;
  localparam logic [3:0] OP_BGT = 4'b1110;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick: the first set request at or above the pointer, wrapping
// modulo NUM_REQ. The grant vector is masked by enable; the index is not.
module alu_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Pick the valid requester with the smallest distance above the pointer
  always_comb begin
    int dist_s;
    int best_s;
    dist_s = 0;
    best_s = NUM_REQ;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = i - int'(ptr);
      if (dist_s < 0) begin
        dist_s = dist_s + NUM_REQ;
      end else begin
        dist_s = dist_s;
      end
      if (req[i] && (dist_s < best_s)) begin
        best_s = dist_s;
        idx    = ID_W'(i);
        any    = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = en && any && (idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; the selected result is
// held in a one-entry tagged response register with full back-to-back throughput.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [CODE_W-1:0]         alu_code,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_accum,
  input  logic                      alu_branch,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_accum,
  output logic                      rsp_branch,
  output logic [15:0]               busy_cnt
);

  slot_state_t         state_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [DATA_W-1:0]   rsp_accum_r;
  logic                rsp_branch_r;
  logic [15:0]         busy_cnt_r;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     ptr_nxt_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     gidx_s;
  logic                any_s;
  logic                can_issue_s;
  logic                accept_s;

  // A new op may enter when the slot is empty or is being drained this cycle
  assign can_issue_s = (state_r == ST_EMPTY) | rsp_ready;

  alu_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .en    (can_issue_s),
    .grant (grant_s),
    .idx   (gidx_s),
    .any   (any_s)
  );

  assign req_ready = grant_s;
  assign accept_s  = |(req_valid & grant_s);

  // Steer the picked requester to the ALU even while stalled; zero when idle
  always_comb begin
    alu_code = '0;
    alu_a    = '0;
    alu_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any_s && (gidx_s == ID_W'(i))) begin
        alu_code = req_code[i*CODE_W +: CODE_W];
        alu_a    = req_a[i*DATA_W +: DATA_W];
        alu_b    = req_b[i*DATA_W +: DATA_W];
      end else begin
        alu_code = alu_code;
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time
  always_comb begin
    if (gidx_s == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gidx_s + ID_W'(1);
    end
  end

  // Slot-occupancy FSM with response register, op counter and RR pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_accum_r  <= '0;
      rsp_branch_r <= 1'b0;
      busy_cnt_r   <= 16'd0;
      ptr_r        <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r     <= ST_FULL;
            rsp_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_EMPTY;
            rsp_valid_r <= 1'b0;
          end
        end
        ST_FULL: begin
          if (accept_s) begin
            state_r     <= ST_FULL;
            rsp_valid_r <= 1'b1;
          end else if (rsp_ready) begin
            state_r     <= ST_EMPTY;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_FULL;
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          rsp_valid_r <= 1'b0;
        end
      endcase
      if (accept_s) begin
        rsp_id_r     <= gidx_s;
        rsp_accum_r  <= alu_accum;
        rsp_branch_r <= alu_branch;
        busy_cnt_r   <= busy_cnt_r + 16'd1;
        ptr_r        <= ptr_nxt_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_accum  = rsp_accum_r;
  assign rsp_branch = rsp_branch_r;
  assign busy_cnt   = busy_cnt_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, queue-based reference model and a
// monitor that scores every response taken by the consumer.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_code;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [CW-1:0]   alu_code;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_accum;
  logic            alu_branch;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_accum;
  logic            rsp_branch;
  logic [15:0]     busy_cnt;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CODE_W(CW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .req_a(req_a), .req_b(req_b),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_accum(alu_accum), .alu_branch(alu_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_accum(rsp_accum), .rsp_branch(rsp_branch),
    .busy_cnt(busy_cnt)
  );

  function automatic void ref_alu(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] acc, output logic br);
    acc = 16'd0;
    br  = 1'b0;
    case (c)
      OP_ADD:  acc = a + b;
      OP_SUB:  acc = a - b;
      OP_BEQ:  br = (a == b);
      OP_BLT:  br = (a < b);
      OP_BGT:  br = (a > b);
      default: acc = 16'd0;
    endcase
  endfunction

  // ALU stand-in connected to the arbiter's ALU ports
  always_comb begin
    ref_alu(alu_code, alu_a, alu_b, alu_accum, alu_branch);
  end

  typedef struct {
    int          id;
    logic [15:0] accum;
    logic        br;
    logic [15:0] cnt;
  } rsp_t;

  rsp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;
  int           m_ptr;
  bit           m_full;
  logic [15:0]  m_cnt;
  logic [N-1:0] s_valid;
  logic [3:0]   s_code[N];
  logic [15:0]  s_a[N];
  logic [15:0]  s_b[N];
  logic         s_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every response handed to the consumer is checked in order
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got id=%0d accum=0x%0h with no pending op", rsp_id, rsp_accum);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        if (int'(rsp_id) != e.id || rsp_accum !== e.accum || rsp_branch !== e.br || busy_cnt !== e.cnt) begin
          fails++;
          $display("FAIL rsp_fields: got id=%0d accum=0x%0h br=%0b cnt=%0d expected id=%0d accum=0x%0h br=%0b cnt=%0d",
                   rsp_id, rsp_accum, rsp_branch, busy_cnt, e.id, e.accum, e.br, e.cnt);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts which requester is accepted
  task automatic step(output int acc_id);
    logic [N-1:0] exp_ready;
    int           pick;
    bit           can;
    rsp_t         e;
    @(posedge clk);
    #1;
    req_valid = s_valid;
    for (int i = 0; i < N; i++) begin
      req_code[i*CW +: CW] = s_code[i];
      req_a[i*DW +: DW]    = s_a[i];
      req_b[i*DW +: DW]    = s_b[i];
    end
    rsp_ready = s_rr;
    can  = !m_full || s_rr;
    pick = -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (m_ptr + k) % N;
      if (pick < 0 && s_valid[r]) pick = r;
    end
    exp_ready = '0;
    acc_id    = -1;
    if (can && pick >= 0) begin
      exp_ready[pick] = 1'b1;
      acc_id = pick;
      m_cnt  = m_cnt + 16'd1;
      e.id   = pick;
      e.cnt  = m_cnt;
      ref_alu(s_code[pick], s_a[pick], s_b[pick], e.accum, e.br);
      sb_q.push_back(e);
      m_ptr  = (pick + 1) % N;
      m_full = 1'b1;
    end else if (s_rr) begin
      m_full = 1'b0;
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (s_valid == '0) chk("alu_idle", {alu_code, alu_a[11:0], alu_b}, 32'd0);
  endtask

  task automatic expect_rsp(input int id, input logic [15:0] acc, input logic br);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_accum", 32'(rsp_accum), 32'(acc));
    chk("rsp_branch", 32'(rsp_branch), 32'(br));
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    s_code[i] = c;
    s_a[i]    = a;
    s_b[i]    = b;
  endtask

  function automatic logic [3:0] rand_code();
    case ($urandom_range(0, 6))
      0:       return OP_ADD;
      1:       return OP_SUB;
      2:       return OP_BEQ;
      3:       return OP_BLT;
      4:       return OP_BGT;
      5:       return OP_NOP;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    m_cnt  = 16'd0;
  endtask

  initial begin
    int g;
    int seq[4];
    int guard;
    logic [3:0]  t4_code[4];
    logic [15:0] t4_a[4];
    logic [15:0] t4_b[4];
    logic [15:0] t4_acc[4];
    logic        t4_br[4];

    rst_n = 1'b0;
    req_valid = '0; req_code = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    s_valid = '0; s_rr = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_NOP, 16'd0, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_accum", 32'(rsp_accum), 32'd0);
    chk("reset_rsp_branch", 32'(rsp_branch), 32'd0);
    chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ADD from requester 0
    s_valid = 2'b01; s_rr = 1'b1; set_req(0, OP_ADD, 16'h0003, 16'h0004);
    step(g);
    chk("t1_accept", 32'(g), 32'd0);
    s_valid = 2'b00;
    step(g);
    expect_rsp(0, 16'h0007, 1'b0);

    // 2: both requesters contending; pointer now sits at 1
    seq = '{1, 0, 1, 0};
    s_valid = 2'b11;
    set_req(0, OP_ADD, 16'h0010, 16'h0001);
    set_req(1, OP_SUB, 16'h0010, 16'h0001);
    for (int c = 0; c < 4; c++) begin
      step(g);
      chk("t2_grant_order", 32'(g), 32'(seq[c]));
    end
    s_valid = 2'b00;
    step(g);
    chk("t2_busy_cnt", 32'(busy_cnt), 32'd5);

    // 3: response held while another op waits
    s_valid = 2'b10; s_rr = 1'b0; set_req(1, OP_BEQ, 16'h1234, 16'h1234);
    step(g);
    chk("t3_accept", 32'(g), 32'd1);
    s_valid = 2'b01; set_req(0, OP_ADD, 16'h0001, 16'h0002);
    repeat (2) begin
      step(g);
      chk("t3_held_ready", 32'(req_ready), 32'd0);
    end
    expect_rsp(1, 16'h0000, 1'b1);
    s_rr = 1'b1;
    step(g);
    chk("t3_release_ready", 32'(req_ready), 32'd1);
    s_valid = 2'b00;
    step(g);
    expect_rsp(0, 16'h0003, 1'b0);

    // 4: wrap-around subtract, compares and an undefined opcode
    t4_code = '{OP_SUB, OP_BLT, OP_BGT, 4'b0011};
    t4_a    = '{16'h0000, 16'd5, 16'd5, 16'd5};
    t4_b    = '{16'h0001, 16'd9, 16'd9, 16'd9};
    t4_acc  = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    t4_br   = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      s_valid = 2'b01; set_req(0, t4_code[t], t4_a[t], t4_b[t]);
      step(g);
      s_valid = 2'b00;
      step(g);
      expect_rsp(0, t4_acc[t], t4_br[t]);
    end

    // Random traffic with drops, stalls and back-to-back issue
    g = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && g != i) begin
          if ($urandom_range(0, 99) < 15) s_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 55) begin
          s_valid[i] = 1'b1;
          s_code[i]  = rand_code();
          s_a[i]     = 16'($urandom);
          s_b[i]     = ($urandom_range(0, 3) == 0) ? s_a[i] : 16'($urandom);
        end else begin
          s_valid[i] = 1'b0;
        end
      end
      s_rr = ($urandom_range(0, 3) != 0);
      step(g);
    end

    // 5: asynchronous reset while a response is held and pointer is 1
    s_valid = 2'b00; s_rr = 1'b1;
    step(g);
    s_valid = 2'b01; s_rr = 1'b0; set_req(0, OP_ADD, 16'h0002, 16'h0002);
    step(g);
    s_valid = 2'b00;
    step(g);
    chk("t5_held_before_reset", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("t5_busy_cnt_async", 32'(busy_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 2'b11; s_rr = 1'b1;
    set_req(0, OP_ADD, 16'h0001, 16'h0001);
    set_req(1, OP_ADD, 16'h0002, 16'h0002);
    step(g);
    chk("t5_first_grant", 32'(req_ready), 32'd1);

    // 6: busy_cnt wraps after 65535 accepts
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step(g);
      guard++;
    end
    chk("t6_reach_ffff", 32'(m_cnt), 32'hFFFF);
    s_valid = 2'b00;
    step(g);
    chk("t6_busy_ffff", 32'(busy_cnt), 32'hFFFF);
    s_valid = 2'b01;
    step(g);
    s_valid = 2'b00;
    step(g);
    chk("t6_busy_wrap", 32'(busy_cnt), 32'd0);
    step(g);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
